// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock types: run/edit state, digit index map and one-hot helper.
// Combinational helpers only; no timing or flow control of its own.
package alarm_clock_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    EDIT = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] DIGIT_SEC_2ND = 3'd0;
  localparam logic [2:0] DIGIT_SEC_1ST = 3'd1;
  localparam logic [2:0] DIGIT_MIN_2ND = 3'd2;
  localparam logic [2:0] DIGIT_MIN_1ST = 3'd3;
  localparam logic [2:0] DIGIT_HR_2ND  = 3'd4;
  localparam logic [2:0] DIGIT_HR_1ST  = 3'd5;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
    logic [NUM_DIGITS-1:0] one;
    one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Front-panel bundle between debouncers/Time/display and the time-set controller.
// Plain level/strobe wires; no handshake, the controller never stalls its inputs.
interface time_set_controller_if;

  logic                                  i_Clk_100Hz_Pulse;
  logic                                  i_Btn_Mode;
  logic                                  i_Btn_Left;
  logic                                  i_Btn_Right;
  logic                                  i_Btn_Up;
  logic                                  i_Btn_Down;
  logic                                  o_Enable_Count;
  logic                                  o_Edit_Mode;
  logic [2:0]                            o_Cursor;
  logic [alarm_clock_pkg::NUM_DIGITS-1:0] o_Digit_Inc;
  logic [alarm_clock_pkg::NUM_DIGITS-1:0] o_Digit_Dec;
  logic [alarm_clock_pkg::NUM_DIGITS-1:0] o_Blank_Mask;

  modport master (
    output i_Clk_100Hz_Pulse, i_Btn_Mode, i_Btn_Left, i_Btn_Right, i_Btn_Up, i_Btn_Down,
    input  o_Enable_Count, o_Edit_Mode, o_Cursor, o_Digit_Inc, o_Digit_Dec, o_Blank_Mask
  );

  modport slave (
    input  i_Clk_100Hz_Pulse, i_Btn_Mode, i_Btn_Left, i_Btn_Right, i_Btn_Up, i_Btn_Down,
    output o_Enable_Count, o_Edit_Mode, o_Cursor, o_Digit_Inc, o_Digit_Dec, o_Blank_Mask
  );

endinterface

// File: rtl/button_repeat.sv
// Up/Down rising-edge detect plus hold-to-repeat counter; events are combinational
// in the cycle of the edge / qualifying tick, never stalled (caller registers them).
module button_repeat #(
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic i_Clk_5MHz,
  input  logic i_Reset_n,
  input  logic i_Tick,
  input  logic i_Enable,
  input  logic i_Up,
  input  logic i_Down,
  output logic o_Up_Event,
  output logic o_Down_Event,
  output logic o_Edge
);

  localparam logic [5:0] DELAY  = 6'(REPEAT_DELAY);
  localparam logic [5:0] RELOAD = 6'(REPEAT_DELAY - REPEAT_PERIOD);

  logic       up_q;
  logic       down_q;
  logic [5:0] rep_cnt;
  logic [5:0] cnt_inc;
  logic       one_held;
  logic       up_edge;
  logic       down_edge;
  logic       rep_fire;

  always_comb begin
    one_held  = i_Up ^ i_Down;
    up_edge   = i_Up & ~up_q;
    down_edge = i_Down & ~down_q;
    o_Edge    = up_edge | down_edge;
    cnt_inc   = rep_cnt + 6'd1;
    rep_fire  = i_Enable & one_held & i_Tick & (cnt_inc >= DELAY);
    // An edge while the other button is held is a chord, not a step.
    o_Up_Event   = i_Enable & ~i_Down & (up_edge | (rep_fire & i_Up));
    o_Down_Event = i_Enable & ~i_Up & (down_edge | (rep_fire & i_Down));
  end

  always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      rep_cnt <= '0;
    end else begin
      up_q   <= i_Up;
      down_q <= i_Down;
      if (!i_Enable || !one_held) begin
        rep_cnt <= '0;
      end else if (i_Tick) begin
        rep_cnt <= (cnt_inc >= DELAY) ? RELOAD : cnt_inc;
      end
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Run/edit sequencer turning five buttons into digit inc/dec strobes, cursor and blink mask.
// All outputs registered, one cycle after the sampled button edge or tick; never backpressures.
module time_set_controller
  import alarm_clock_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10,
  parameter int BLINK_PERIOD  = 50,
  parameter int TIMEOUT       = 1000
) (
  input  logic                 i_Clk_5MHz,
  input  logic                 i_Reset_n,
  time_set_controller_if.slave bus
);

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);
  localparam logic [5:0] BLINK_LAST  = 6'(BLINK_PERIOD - 1);
  localparam logic [5:0] BLINK_HALF  = 6'(BLINK_PERIOD / 2);

  state_t                state;
  logic [2:0]            cursor;
  logic [5:0]            blink_cnt;
  logic [9:0]            tmo_cnt;
  logic                  mode_q;
  logic                  left_q;
  logic                  right_q;
  logic                  enable_count;
  logic                  edit_mode;
  logic [NUM_DIGITS-1:0] digit_inc;
  logic [NUM_DIGITS-1:0] digit_dec;
  logic [NUM_DIGITS-1:0] blank_mask;

  logic       tick;
  logic       mode_edge;
  logic       left_edge;
  logic       right_edge;
  logic       ud_edge;
  logic       any_edge;
  logic       in_edit;
  logic       exit_edit;
  logic       rep_en;
  logic       strobe_ok;
  logic       up_evt;
  logic       down_evt;
  logic [9:0] tmo_inc;
  logic [9:0] tmo_nxt;
  logic [5:0] blink_nxt;
  logic [2:0] cursor_nxt;

  button_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_button_repeat (
    .i_Clk_5MHz  (i_Clk_5MHz),
    .i_Reset_n   (i_Reset_n),
    .i_Tick      (tick),
    .i_Enable    (rep_en),
    .i_Up        (bus.i_Btn_Up),
    .i_Down      (bus.i_Btn_Down),
    .o_Up_Event  (up_evt),
    .o_Down_Event(down_evt),
    .o_Edge      (ud_edge)
  );

  always_comb begin
    tick       = bus.i_Clk_100Hz_Pulse;
    mode_edge  = bus.i_Btn_Mode & ~mode_q;
    left_edge  = bus.i_Btn_Left & ~left_q;
    right_edge = bus.i_Btn_Right & ~right_q;
    any_edge   = mode_edge | left_edge | right_edge | ud_edge;
    in_edit    = (state == EDIT);
    tmo_inc    = tmo_cnt + 10'd1;
    exit_edit  = in_edit & (mode_edge | (~any_edge & tick & (tmo_inc >= TIMEOUT_CNT)));
    rep_en     = in_edit & ~exit_edit;
    // Any Left/Right edge (even a cancelling pair) outranks Up/Down this cycle.
    strobe_ok  = ~left_edge & ~right_edge;

    cursor_nxt = cursor;
    if (left_edge && !right_edge) begin
      cursor_nxt = (cursor == DIGIT_HR_1ST) ? DIGIT_SEC_2ND : cursor + 3'd1;
    end else if (right_edge && !left_edge) begin
      cursor_nxt = (cursor == DIGIT_SEC_2ND) ? DIGIT_HR_1ST : cursor - 3'd1;
    end

    blink_nxt = blink_cnt;
    tmo_nxt   = tmo_cnt;
    if (any_edge) begin
      blink_nxt = '0;
      tmo_nxt   = '0;
    end else if (tick) begin
      blink_nxt = (blink_cnt == BLINK_LAST) ? 6'd0 : blink_cnt + 6'd1;
      tmo_nxt   = tmo_inc;
    end
  end

  always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state        <= RUN;
      cursor       <= DIGIT_HR_1ST;
      blink_cnt    <= '0;
      tmo_cnt      <= '0;
      mode_q       <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      enable_count <= 1'b1;
      edit_mode    <= 1'b0;
      digit_inc    <= '0;
      digit_dec    <= '0;
      blank_mask   <= '0;
    end else begin
      mode_q     <= bus.i_Btn_Mode;
      left_q     <= bus.i_Btn_Left;
      right_q    <= bus.i_Btn_Right;
      digit_inc  <= '0;
      digit_dec  <= '0;
      blank_mask <= '0;
      case (state)
        RUN: begin
          if (mode_edge) begin
            state        <= EDIT;
            cursor       <= DIGIT_HR_1ST;
            blink_cnt    <= '0;
            tmo_cnt      <= '0;
            enable_count <= 1'b0;
            edit_mode    <= 1'b1;
          end
        end
        EDIT: begin
          if (exit_edit) begin
            state        <= RUN;
            blink_cnt    <= '0;
            tmo_cnt      <= '0;
            enable_count <= 1'b1;
            edit_mode    <= 1'b0;
          end else begin
            cursor    <= cursor_nxt;
            blink_cnt <= blink_nxt;
            tmo_cnt   <= tmo_nxt;
            if (strobe_ok && up_evt) begin
              digit_inc <= digit_onehot(cursor);
            end
            if (strobe_ok && down_evt) begin
              digit_dec <= digit_onehot(cursor);
            end
            // Mask follows the post-update cursor so a move shows on the new digit at once.
            if (blink_nxt >= BLINK_HALF) begin
              blank_mask <= digit_onehot(cursor_nxt);
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.o_Enable_Count = enable_count;
  assign bus.o_Edit_Mode    = edit_mode;
  assign bus.o_Cursor       = cursor;
  assign bus.o_Digit_Inc    = digit_inc;
  assign bus.o_Digit_Dec    = digit_dec;
  assign bus.o_Blank_Mask   = blank_mask;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed front-panel sequences plus random button traffic,
// all outputs compared every cycle against a behavioural model of the panel rules.
`timescale 1ns/1ps
module tb_time_set_controller;

  localparam int RD = 50;
  localparam int RP = 10;
  localparam int BP = 50;
  localparam int TO = 1000;

  // btn index: 0 Mode, 1 Left, 2 Right, 3 Up, 4 Down
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;
  logic       tick = 1'b0;
  bit         chk_on = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  time_set_controller_if bus ();

  assign bus.i_Clk_100Hz_Pulse = tick;
  assign bus.i_Btn_Mode        = btn[0];
  assign bus.i_Btn_Left        = btn[1];
  assign bus.i_Btn_Right       = btn[2];
  assign bus.i_Btn_Up          = btn[3];
  assign bus.i_Btn_Down        = btn[4];

  time_set_controller #(
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .BLINK_PERIOD (BP),
    .TIMEOUT      (TO)
  ) dut (
    .i_Clk_5MHz(clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input int b);
    btn[b] = 1'b1;
    step();
    btn[b] = 1'b0;
  endtask

  // Behavioural model: panel state as plain integers, advanced once per clock.
  int         m_edit, m_cur, m_blink, m_tmo, m_rep;
  logic [4:0] m_prev;
  logic [5:0] e_inc, e_dec, e_mask;

  always @(posedge clk or negedge rst_n) begin
    logic [4:0] e;
    bit up, dn, fire;
    if (!rst_n) begin
      m_edit = 0; m_cur = 5; m_blink = 0; m_tmo = 0; m_rep = 0;
      m_prev = '0; e_inc = '0; e_dec = '0; e_mask = '0;
    end else begin
      e = btn & ~m_prev;
      m_prev = btn;
      up = btn[3];
      dn = btn[4];
      e_inc = '0;
      e_dec = '0;
      if (m_edit == 0) begin
        m_rep = 0;
        if (e[0]) begin
          m_edit = 1; m_cur = 5; m_blink = 0; m_tmo = 0;
        end
      end else if (e[0] || (e == 0 && tick && m_tmo + 1 >= TO)) begin
        m_edit = 0; m_rep = 0; m_blink = 0; m_tmo = 0;
      end else begin
        fire = 0;
        if (up != dn) begin
          if (tick) begin
            m_rep++;
            if (m_rep >= RD) begin
              fire = 1;
              m_rep = RD - RP;
            end
          end
        end else begin
          m_rep = 0;
        end
        if (e[1] || e[2]) begin
          if (e[1] && !e[2]) m_cur = (m_cur + 1) % 6;
          if (e[2] && !e[1]) m_cur = (m_cur + 5) % 6;
        end else if (up && !dn && (e[3] || fire)) begin
          e_inc = 6'b000001 << m_cur;
        end else if (dn && !up && (e[4] || fire)) begin
          e_dec = 6'b000001 << m_cur;
        end
        if (e != 0) begin
          m_blink = 0; m_tmo = 0;
        end else if (tick) begin
          m_blink = (m_blink + 1) % BP;
          m_tmo++;
        end
      end
      e_mask = (m_edit != 0 && m_blink >= BP / 2) ? (6'b000001 << m_cur) : 6'b000000;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("enable_count", bus.o_Enable_Count, (m_edit != 0) ? 0 : 1);
      chk("edit_mode", bus.o_Edit_Mode, m_edit);
      chk("cursor", bus.o_Cursor, m_cur);
      chk("digit_inc", bus.o_Digit_Inc, e_inc);
      chk("digit_dec", bus.o_Digit_Dec, e_dec);
      chk("blank_mask", bus.o_Blank_Mask, e_mask);
      chk("strobe_onehot", ($countones(bus.o_Digit_Inc | bus.o_Digit_Dec) <= 1) ? 1 : 0, 1);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int right_exp[6];
    right_exp = '{4, 3, 2, 1, 0, 5};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_enable", bus.o_Enable_Count, 1);
    chk("rst_edit", bus.o_Edit_Mode, 0);
    chk("rst_cursor", bus.o_Cursor, 5);
    chk("rst_inc", bus.o_Digit_Inc, 0);
    chk("rst_dec", bus.o_Digit_Dec, 0);
    chk("rst_mask", bus.o_Blank_Mask, 0);
    chk_on = 1;
    rst_n = 1'b1;
    step();

    // Mode in, Mode out, Mode in again
    hit(0);
    chk("enter_edit", bus.o_Edit_Mode, 1);
    chk("enter_enable", bus.o_Enable_Count, 0);
    chk("enter_cursor", bus.o_Cursor, 5);
    step();
    hit(0);
    chk("exit_edit", bus.o_Edit_Mode, 0);
    chk("exit_enable", bus.o_Enable_Count, 1);
    step();
    hit(0);
    step();

    for (int i = 0; i < 6; i++) begin
      hit(2);
      chk("right_walk", bus.o_Cursor, right_exp[i]);
      step();
    end
    hit(1);
    chk("left_wrap", bus.o_Cursor, 0);
    step();
    btn[1] = 1'b1;
    btn[2] = 1'b1;
    step();
    chk("left_right_same", bus.o_Cursor, 0);
    btn[1] = 1'b0;
    btn[2] = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      hit(1);
      step();
    end
    chk("cursor_at_3", bus.o_Cursor, 3);

    hit(3);
    chk("up_tap_inc", bus.o_Digit_Inc, 6'b001000);
    chk("up_tap_dec", bus.o_Digit_Dec, 0);
    step();
    chk("up_tap_one_cycle", bus.o_Digit_Inc, 0);
    hit(4);
    chk("down_tap_dec", bus.o_Digit_Dec, 6'b001000);
    step();
    chk("down_tap_one_cycle", bus.o_Digit_Dec, 0);

    // Up held through 100 ticks
    btn[3] = 1'b1;
    step();
    n = (bus.o_Digit_Inc != 0) ? 1 : 0;
    for (int t = 1; t <= 100; t++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (bus.o_Digit_Inc != 0) n++;
      step();
      if (bus.o_Digit_Inc != 0) n++;
      step();
      if (bus.o_Digit_Inc != 0) n++;
    end
    btn[3] = 1'b0;
    step();
    chk("hold_up_strobes", n, 7);

    // Up and Down held together
    btn[3] = 1'b1;
    btn[4] = 1'b1;
    n = 0;
    for (int t = 1; t <= 100; t++) begin
      step();
      if ((bus.o_Digit_Inc | bus.o_Digit_Dec) != 0) n++;
      tick = 1'b1;
      step();
      tick = 1'b0;
      if ((bus.o_Digit_Inc | bus.o_Digit_Dec) != 0) n++;
    end
    btn[3] = 1'b0;
    btn[4] = 1'b0;
    step();
    chk("chord_strobes", n, 0);

    hit(1);
    step();
    hit(1);
    step();
    chk("cursor_at_5", bus.o_Cursor, 5);

    // Idle: blink phase and timeout
    for (int k = 1; k < TO; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("idle_still_edit", bus.o_Edit_Mode, 1);
      chk("idle_blink", bus.o_Blank_Mask, ((k % BP) >= BP / 2) ? 6'b100000 : 6'b000000);
      step();
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("timeout_edit", bus.o_Edit_Mode, 0);
    chk("timeout_enable", bus.o_Enable_Count, 1);
    chk("timeout_mask", bus.o_Blank_Mask, 0);
    step();

    // Reset while Up is auto-repeating
    hit(0);
    step();
    btn[3] = 1'b1;
    for (int t = 0; t < 55; t++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_enable", bus.o_Enable_Count, 1);
    chk("arst_edit", bus.o_Edit_Mode, 0);
    chk("arst_cursor", bus.o_Cursor, 5);
    chk("arst_inc", bus.o_Digit_Inc, 0);
    chk("arst_dec", bus.o_Digit_Dec, 0);
    chk("arst_mask", bus.o_Blank_Mask, 0);
    step();
    step();
    rst_n = 1'b1;
    n = 0;
    for (int t = 0; t < 60; t++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (bus.o_Digit_Inc != 0) n++;
      step();
      if (bus.o_Digit_Inc != 0) n++;
    end
    btn[3] = 1'b0;
    step();
    chk("post_reset_strobes", n, 0);

    // Random traffic at three button-activity rates
    for (int seg = 0; seg < 3; seg++) begin
      int rate;
      rate = (seg == 0) ? 20 : (seg == 1) ? 300 : 1500;
      for (int c = 0; c < 6000; c++) begin
        for (int b = 0; b < 5; b++) begin
          if ($urandom_range(0, (b == 0) ? rate * 8 - 1 : rate - 1) == 0) btn[b] = ~btn[b];
        end
        tick = ($urandom_range(0, 3) == 0);
        step();
      end
    end
    btn = '0;
    tick = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Front-panel controller that sequences manual time setting for the `Time` block. It turns five debounced buttons into the 12 single-cycle digit inc/dec strobes that `Time` accepts, and gates `i_Enable_Count` while editing. It also drives a cursor and blink mask for the display driver. It sits between the button debouncers and `Time` in the alarm-clock top level, on the 5 MHz domain.

## Interface
Parameters:
- REPEAT_DELAY, 50, 100 Hz ticks a single Up/Down must be held before auto-repeat starts (0.5 s)
- REPEAT_PERIOD, 10, ticks between auto-repeat strobes (0.1 s)
- BLINK_PERIOD, 50, blink period in ticks; the digit is blanked for the second half
- TIMEOUT, 1000, ticks without a button edge before EDIT exits automatically (10 s)

Ports:
- i_Clk_5MHz  in  1  system clock, all logic rising-edge
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Clk_100Hz_Pulse  in  1  one-cycle tick at 100 Hz
- i_Btn_Mode, i_Btn_Left, i_Btn_Right, i_Btn_Up, i_Btn_Down  in  1 each  debounced levels, synchronous to i_Clk_5MHz
- o_Enable_Count  out  1  drives `Time` i_Enable_Count
- o_Edit_Mode  out  1  high in EDIT
- o_Cursor  out  3  selected digit index, 0..5
- o_Digit_Inc  out  6  one-hot inc strobes
- o_Digit_Dec  out  6  one-hot dec strobes
- o_Blank_Mask  out  6  digit blanking for the display

Digit index map: 0 = seconds 2nd, 1 = seconds 1st, 2 = minutes 2nd, 3 = minutes 1st, 4 = hours 2nd, 5 = hours 1st.

## Operation
- Rising edges are detected on all buttons using registered previous levels.
- States:
  - RUN: o_Enable_Count = 1; only Mode is honoured.
  - EDIT: counting is stopped; the cursor and strobes are active.
- RUN→EDIT on a Mode edge. On entry, cursor = 5, blink counter = 0, timeout counter = 0.
- EDIT→RUN on a Mode edge, or when the timeout counter reaches TIMEOUT.
- Priority within one cycle is Mode > Left/Right > Up/Down. Lower-priority edges in the same cycle are discarded.
- Cursor movement:
  - Left: cursor+1, wrapping 5→0.
  - Right: cursor−1, wrapping 0→5.
  - Left and Right edges in the same cycle: both ignored.
- Up/Down strobes:
  - An Up (Down) edge asserts o_Digit_Inc[cursor] (o_Digit_Dec[cursor]) for exactly one cycle.
  - Up and Down held together: no strobes, and the repeat counter is held at 0.
- Auto-repeat:
  - The repeat counter counts ticks while exactly one of Up/Down stays high.
  - At REPEAT_DELAY it emits one strobe and reloads to REPEAT_DELAY−REPEAT_PERIOD.
  - Releasing the button clears the counter.
- Any button edge in EDIT clears both the timeout counter and the blink counter.
- Blink: the blink counter (0..BLINK_PERIOD−1) advances on each tick in EDIT. o_Blank_Mask = one-hot(cursor) when count ≥ BLINK_PERIOD/2, otherwise 0. The mask is always 0 in RUN.
- Cursor changes are reflected in o_Blank_Mask immediately; the blink phase restarts.
- At most one bit across o_Digit_Inc | o_Digit_Dec is ever high.

## Timing
- All outputs are registered.
- Reset values: o_Enable_Count = 1, o_Edit_Mode = 0, o_Cursor = 5, o_Digit_Inc = 0, o_Digit_Dec = 0, o_Blank_Mask = 0. All counters and edge registers = 0.
- Button level rises at cycle n (first sampled high):
  - Strobe, cursor update and state change are visible at n+1.
  - o_Enable_Count falls at n+1 on entry to EDIT and rises at n+1 on exit.
- Auto-repeat strobe: asserted the cycle after the tick that brings the counter to REPEAT_DELAY. Held Up gives strobes at the edge, at tick 50, then every 10 ticks.
- Timeout exit: occurs the cycle after the TIMEOUT-th tick with no edges.
- Exiting EDIT forces strobes low and the mask to 0 that same cycle; the repeat counter clears.
- Async reset mid-edit returns immediately to RUN with the reset values above.
- Counter widths: 10-bit timeout, 6-bit blink, 6-bit repeat. Counter comparisons are unsigned.

## Structure
- Shared package `alarm_clock_pkg`:
  - state enum (RUN, EDIT)
  - digit index constants (DIGIT_SEC_2ND..DIGIT_HR_1ST)
  - NUM_DIGITS = 6
- One sub-module, `button_repeat`, instantiated once and fed Up/Down:
  - edge detect and repeat counter
  - outputs o_Up_Event and o_Down_Event
- The FSM, cursor, blink and timeout logic live in the top.

## Test plan
- Reset then Mode press → o_Edit_Mode = 1, o_Enable_Count = 0, o_Cursor = 5 at n+1; a second Mode press → RUN, o_Enable_Count = 1.
- In EDIT, Right ×6 → cursor 4,3,2,1,0,5; Left from 5 → 0; Left and Right in the same cycle → cursor unchanged.
- Cursor = 3, Up tapped → o_Digit_Inc = 6'b001000 for exactly 1 cycle; Down tapped → o_Digit_Dec = 6'b001000.
- Up held 100 ticks → strobes at the edge, then at ticks 50, 60, 70, 80, 90, 100 (7 total); Up and Down held together → 0 strobes.
- Idle 999 ticks → still EDIT; 1000th tick → RUN. Blank mask = 6'b100000 during ticks 25–49 of each 50-tick period only.
- Assert i_Reset_n low while Up is repeating in EDIT → all outputs take reset values asynchronously, and no strobe follows release of reset.
